// File: rtl/kdf_arbiter.sv
// Round-robin owner of a single spongent KDF core: grants one requester, runs the core, returns key + ack.
// Latency: ack T+2 cycles after grant (T = RUN cycles to kdf_end), 1 cycle for count==0, watchdog-bounded.
// Backpressure: requests are held by clients; new grants only happen in IDLE, one job in flight at a time.
module kdf_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int N           = 128,
  parameter int SALT_WIDTH  = 64,
  parameter int COUNT_WIDTH = 32,
  parameter int PSW_WIDTH   = 80,
  parameter int TO_WIDTH    = 24
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*SALT_WIDTH-1:0]  salt_in,
  input  logic [NUM_REQ*COUNT_WIDTH-1:0] count_in,
  input  logic [NUM_REQ*PSW_WIDTH-1:0]   psw_in,
  output logic [NUM_REQ-1:0]             ack,
  output logic [N-1:0]                   key_out,
  output logic                           err,
  output logic                           busy,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           kdf_rst,
  output logic [SALT_WIDTH-1:0]          kdf_salt,
  output logic [COUNT_WIDTH-1:0]         kdf_count,
  output logic [PSW_WIDTH-1:0]           kdf_psw,
  input  logic                           kdf_end,
  input  logic [N-1:0]                   kdf_key
);

  localparam int GW = $clog2(NUM_REQ);
  // Watchdog value during the last permitted RUN cycle; the increment on that edge reaches all-ones.
  localparam logic [TO_WIDTH-1:0] WD_LAST = {{(TO_WIDTH-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

  state_t                  state, state_nxt;
  logic [TO_WIDTH-1:0]     wd;
  logic [GW-1:0]           idx;
  logic [GW-1:0]           win;
  logic                    found;
  logic [NUM_REQ-1:0]      win_oh;
  logic [NUM_REQ-1:0]      gnt_oh;
  logic [SALT_WIDTH-1:0]   sel_salt;
  logic [COUNT_WIDTH-1:0]  sel_count;
  logic [PSW_WIDTH-1:0]    sel_psw;
  logic                    wd_exp;

  assign wd_exp = (wd == WD_LAST);

  // Round-robin search: first set req bit strictly after grant_id, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    win   = grant_id;
    idx   = grant_id;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (idx == GW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Operand mux for the winning client plus one-hot decodes of winner and current grant.
  always_comb begin
    sel_salt  = '0;
    sel_count = '0;
    sel_psw   = '0;
    win_oh    = '0;
    gnt_oh    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == GW'(i)) begin
        sel_salt  = salt_in[i*SALT_WIDTH +: SALT_WIDTH];
        sel_count = count_in[i*COUNT_WIDTH +: COUNT_WIDTH];
        sel_psw   = psw_in[i*PSW_WIDTH +: PSW_WIDTH];
      end
    end
    win_oh[win]      = 1'b1;
    gnt_oh[grant_id] = 1'b1;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; a zero count skips the core entirely, kdf_end beats a coincident timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = (sel_count == '0) ? DONE : START;
      START:   state_nxt = RUN;
      RUN:     if (kdf_end || wd_exp) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs and datapath: operands latch only at grant, key/err update only on job completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kdf_rst   <= 1'b1;
      busy      <= 1'b0;
      ack       <= '0;
      err       <= 1'b0;
      key_out   <= '0;
      grant_id  <= GW'(NUM_REQ - 1);
      kdf_salt  <= '0;
      kdf_count <= '0;
      kdf_psw   <= '0;
      wd        <= '0;
    end else begin
      kdf_rst <= (state_nxt != RUN);
      busy    <= (state_nxt != IDLE);
      ack     <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            grant_id  <= win;
            kdf_salt  <= sel_salt;
            kdf_count <= sel_count;
            kdf_psw   <= sel_psw;
            if (sel_count == '0) begin
              key_out <= '0;
              err     <= 1'b1;
              ack     <= win_oh;
            end
          end
        end
        START: wd <= '0;
        RUN: begin
          wd <= wd + 1'b1;
          if (kdf_end) begin
            key_out <= kdf_key;
            err     <= 1'b0;
            ack     <= gnt_oh;
          end else if (wd_exp) begin
            key_out <= '0;
            err     <= 1'b1;
            ack     <= gnt_oh;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
